// File: rtl/regfile_sb.sv
// Multi-port register file with write-first bypass, a PC-mapped read-only register
// and a per-register load scoreboard used by decode to stall on pending loads.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int PC_REG   = NREGS - 1,
  parameter int SP_REG   = NREGS - 3,
  parameter int PC_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  ld_wr_en,
  input  logic [ADDR_W-1:0]     ld_wr_addr,
  input  logic [DATA_W-1:0]     ld_wr_data,
  input  logic                  ld_issue,
  input  logic [ADDR_W-1:0]     ld_issue_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic                  waw_err
);

  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_REG);
  localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NREGS);

  logic [DATA_W-1:0] reg_val [NREGS];
  logic [NREGS-1:0]  busy;
  logic [DATA_W-1:0] pc_view;
  logic              wr_ok, ld_ok, issue_ok;
  logic              err_now;
  logic              waw_err_reg;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic busy_at(input logic [NREGS-1:0] b, input logic [ADDR_W-1:0] a);
    return in_range(a) ? b[a] : 1'b0;
  endfunction

  assign pc_view = pc >> PC_SHIFT;

  // Writes during reset are dropped so a reset cleanly abandons in-flight loads.
  assign wr_ok    = wr_en && (wr_addr != PC_A) && !reset;
  assign ld_ok    = ld_wr_en && (ld_wr_addr != PC_A) && !reset;
  assign issue_ok = ld_issue && (ld_issue_addr != PC_A);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == PC_REG) begin : g_pc
        assign reg_val[gi] = '0;
        assign busy[gi]    = 1'b0;
      end else begin : g_store
        logic [DATA_W-1:0] q_reg;
        logic              busy_q_reg;

        // ALU write wins over load return: it is the younger instruction.
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= (gi == SP_REG) ? '1 : '0;
          end else if (wr_ok && wr_addr == ADDR_W'(gi)) begin
            q_reg <= wr_data;
          end else if (ld_ok && ld_wr_addr == ADDR_W'(gi)) begin
            q_reg <= ld_wr_data;
          end
        end

        // A fresh issue outranks a same-cycle writeback of the older load.
        always_ff @(posedge clk) begin
          if (reset) begin
            busy_q_reg <= 1'b0;
          end else if (issue_ok && ld_issue_addr == ADDR_W'(gi)) begin
            busy_q_reg <= 1'b1;
          end else if (ld_ok && ld_wr_addr == ADDR_W'(gi)) begin
            busy_q_reg <= 1'b0;
          end
        end

        assign reg_val[gi] = q_reg;
        assign busy[gi]    = busy_q_reg;
      end
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;

      assign a = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        d = '0;
        b = 1'b0;
        if (a == PC_A) begin
          d = pc_view;
        end else if (in_range(a)) begin
          if (wr_ok && wr_addr == a) begin
            d = wr_data;
          end else if (ld_ok && ld_wr_addr == a) begin
            d = ld_wr_data;
          end else begin
            d = reg_val[a];
          end
          b = busy[a] && !(ld_ok && ld_wr_addr == a);
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = d;
      assign rd_busy[gi]                  = b;
    end
  endgenerate

  always_comb begin
    err_now = 1'b0;
    if (wr_ok && busy_at(busy, wr_addr)) begin
      err_now = 1'b1;
    end
    if (issue_ok && busy_at(busy, ld_issue_addr) && !(ld_ok && ld_wr_addr == ld_issue_addr)) begin
      err_now = 1'b1;
    end
    if (ld_wr_en && !busy_at(busy, ld_wr_addr)) begin
      err_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waw_err_reg <= 1'b0;
    end else if (err_now) begin
      waw_err_reg <= 1'b1;
    end
  end

  assign waw_err = waw_err_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected reads are queued as stimulus is driven
// and popped/compared against the combinational outputs mid-cycle.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pc;
  logic          wr_en, ld_wr_en, ld_issue;
  logic [AW-1:0] wr_addr, ld_wr_addr, ld_issue_addr;
  logic [DW-1:0] wr_data, ld_wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             waw_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  exp_t sb[$];

  regfile_sb dut (
    .clk(clk), .reset(reset), .pc(pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_en    = 1'b0;
    ld_wr_en = 1'b0;
    ld_issue = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic expect_rd(input string tag, input int k, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic b);
    exp_t e;
    set_rd(k, a);
    e.tag = tag; e.port = k; e.data = d; e.busy = b;
    sb.push_back(e);
  endtask

  // Sample at the falling edge, away from the active edge.
  task automatic check_reads();
    exp_t e;
    logic [DW-1:0] got_d;
    logic          got_b;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got_d = rd_data[e.port*DW +: DW];
      got_b = rd_busy[e.port];
      total++;
      assert (got_d === e.data) else begin
        bad++;
        $error("FAIL %s data: got %h expected %h", e.tag, got_d, e.data);
      end
      total++;
      assert (got_b === e.busy) else begin
        bad++;
        $error("FAIL %s busy: got %b expected %b", e.tag, got_b, e.busy);
      end
      $display("check %s port%0d data=%h busy=%b", e.tag, e.port, got_d, got_b);
    end
  endtask

  task automatic check_err(input string tag, input logic exp_e);
    total++;
    assert (waw_err === exp_e) else begin
      bad++;
      $error("FAIL %s waw_err: got %b expected %b", tag, waw_err, exp_e);
    end
    $display("check %s waw_err=%b", tag, waw_err);
  endtask

  initial begin
    reset = 1'b1; pc = 16'h0040;
    wr_en = 1'b0; ld_wr_en = 1'b0; ld_issue = 1'b0;
    wr_addr = '0; ld_wr_addr = '0; ld_issue_addr = '0;
    wr_data = '0; ld_wr_data = '0; rd_addr = '0;

    // Reset values
    step();
    expect_rd("rst_r0", 0, 4'd0, 16'h0000, 1'b0);
    expect_rd("rst_r13", 1, 4'd13, 16'hFFFF, 1'b0);
    check_reads();
    check_err("rst", 1'b0);
    expect_rd("rst_r15", 0, 4'd15, 16'h0010, 1'b0);
    check_reads();

    // Bypass and collision: ALU data wins; load to non-busy r3 flags an error
    step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    ld_wr_en = 1'b1; ld_wr_addr = 4'd3; ld_wr_data = 16'hABCD;
    expect_rd("coll_byp", 0, 4'd3, 16'h1234, 1'b0);
    check_reads();
    step();
    expect_rd("coll_store", 0, 4'd3, 16'h1234, 1'b0);
    check_reads();
    check_err("coll_ld_not_busy", 1'b1);

    // Fresh reset, then PC protection
    step();
    reset = 1'b1;
    step();
    check_err("reset2", 1'b0);
    pc = 16'h1234;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hFFFF;
    expect_rd("pcw_byp", 0, 4'd15, 16'h048D, 1'b0);
    expect_rd("pcw_r14", 1, 4'd14, 16'h0000, 1'b0);
    check_reads();
    step();
    expect_rd("pcw_r15", 0, 4'd15, 16'h048D, 1'b0);
    expect_rd("pcw_r13", 1, 4'd13, 16'hFFFF, 1'b0);
    check_reads();
    expect_rd("pcw_r0", 0, 4'd0, 16'h0000, 1'b0);
    expect_rd("pcw_r14b", 1, 4'd14, 16'h0000, 1'b0);
    check_reads();

    // Scoreboard on r5
    step();
    ld_issue = 1'b1; ld_issue_addr = 4'd5;
    expect_rd("sb_issue_cyc", 0, 4'd5, 16'h0000, 1'b0);
    check_reads();
    step();
    expect_rd("sb_r5_busy", 0, 4'd5, 16'h0000, 1'b1);
    check_reads();
    step();
    step();
    step();
    ld_wr_en = 1'b1; ld_wr_addr = 4'd5; ld_wr_data = 16'h00AA;
    expect_rd("sb_wb_byp", 0, 4'd5, 16'h00AA, 1'b0);
    check_reads();
    step();
    expect_rd("sb_r5_clear", 0, 4'd5, 16'h00AA, 1'b0);
    check_reads();
    check_err("sb_clean", 1'b0);

    // Simultaneous issue and writeback on busy r7
    step();
    ld_issue = 1'b1; ld_issue_addr = 4'd7;
    step();
    ld_issue = 1'b1; ld_issue_addr = 4'd7;
    ld_wr_en = 1'b1; ld_wr_addr = 4'd7; ld_wr_data = 16'h0777;
    expect_rd("sim_byp", 1, 4'd7, 16'h0777, 1'b0);
    check_reads();
    step();
    expect_rd("sim_busy", 1, 4'd7, 16'h0777, 1'b1);
    check_reads();
    check_err("sim_no_err", 1'b0);
    ld_wr_en = 1'b1; ld_wr_addr = 4'd7; ld_wr_data = 16'h0707;
    step();
    expect_rd("sim_clear", 1, 4'd7, 16'h0707, 1'b0);
    check_reads();
    check_err("sim_clear_err", 1'b0);

    // ALU write to busy r9 is an error, data still lands
    ld_issue = 1'b1; ld_issue_addr = 4'd9;
    step();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h9999;
    step();
    expect_rd("err_r9", 0, 4'd9, 16'h9999, 1'b1);
    check_reads();
    check_err("err_set", 1'b1);

    // Reset mid-load drops the load, even with a writeback in the reset cycle
    reset = 1'b1;
    ld_wr_en = 1'b1; ld_wr_addr = 4'd9; ld_wr_data = 16'h5555;
    step();
    expect_rd("rstld_r9", 0, 4'd9, 16'h0000, 1'b0);
    check_reads();
    check_err("rstld_err", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
